stage_fetch: RTL and testbench

//  Front pipeline stage; drives the decode stage's de_valid/de_insn/de_pc and obeys its de_stall.

---
 rtl/stage_fetch_pkg.sv | 20 ++
 rtl/stage_fetch_if.sv | 19 +
 rtl/stage_fetch_fifo.sv | 65 ++++++
 rtl/stage_fetch.sv | 107 ++++++++++
 tb/tb_stage_fetch.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_fetch_pkg.sv
// Shared types and constants for the fetch stage.
package stage_fetch_pkg;

  // Fetch state encodings (kept as plain constants for the legacy netlist flow)
  localparam logic [0:0] FE_RUN   = 1'b0;
  localparam logic [0:0] FE_FAULT = 1'b1;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  // One instruction buffer entry: the word plus the PC it was fetched from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_fetch_if.sv
// Instruction memory request/response bus between fetch and imem.
interface stage_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err
  );
endinterface

// File: rtl/stage_fetch_fifo.sv
// Synchronous instruction buffer of {pc, insn} entries with flush and count.
module fetch_fifo
  import stage_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            full;
  logic            do_push;
  logic            do_pop;

  // Push on a full buffer is only legal when the head leaves in the same cycle
  always_comb begin
    empty   = (cnt == '0);
    full    = (cnt == FULL_CNT);
    do_pop  = pop && !empty;
    do_push = push && (!full || pop);
    head    = mem[rd_ptr];
    count   = cnt;
  end

  // Pointer and occupancy tracking; flush empties the buffer in one cycle
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage; cleared on reset so the head reads zero until the first push
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/stage_fetch.sv
// Front pipeline stage: PC sequencing, credit-limited imem reads, redirect drop.
module stage_fetch
  import stage_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               de_valid,
  output logic [31:0]        de_insn,
  output logic [31:0]        de_pc,
  input  logic               de_stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  stage_fetch_if.master      imem,
  output logic               fe_fault
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic [0:0]    state;
  logic          issue;
  logic          rsp_drop;
  logic          rsp_take;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  // Issue is credit-limited so every outstanding response has a buffer slot
  always_comb begin
    credit_used      = {1'b0, fifo_count} + {1'b0, outstanding};
    imem.imem_req    = !reset && (state == FE_RUN) && !redirect && (credit_used < CREDITS);
    imem.imem_addr   = pc;
    issue            = imem.imem_req && imem.imem_gnt;
    rsp_drop         = (drop != '0);
    rsp_take         = imem.imem_rvalid && !rsp_drop && (state == FE_RUN) && !redirect;
    push             = rsp_take && !imem.imem_err;
    pop              = de_valid && !de_stall;
    outstanding_next = outstanding + CW'(issue) - CW'(imem.imem_rvalid);
    push_data        = '{pc: rsp_pc, insn: imem.imem_rdata};
    de_valid         = !fifo_empty;
    de_insn          = head.insn;
    de_pc            = head.pc;
    fe_fault         = (state == FE_FAULT);
  end

  // PC, response-PC tracking, credit/drop counters and run/fault state.
  // rsp_pc follows the oldest surviving request so de_pc needs no per-request queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      state       <= FE_RUN;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        pc     <= word_align(redirect_pc);
        rsp_pc <= word_align(redirect_pc);
        drop   <= outstanding_next;
        state  <= FE_RUN;
      end else begin
        if (issue) pc <= pc + 32'd4;
        if (imem.imem_rvalid && rsp_drop) drop <= drop - 1'b1;
        if (rsp_take) begin
          if (imem.imem_err) state  <= FE_FAULT;
          else               rsp_pc <= rsp_pc + 32'd4;
        end
      end
    end
  end

  // Counter sanity: a response needs a request in flight, drops never exceed it
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (imem.imem_rvalid) assert (outstanding != '0);
      assert (drop <= outstanding);
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch with an in-order imem responder.
module tb_stage_fetch;

  logic        clk;
  logic        reset;
  logic        de_valid;
  logic [31:0] de_insn;
  logic [31:0] de_pc;
  logic        de_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fe_fault;

  stage_fetch_if imem_bus ();

  stage_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .de_valid    (de_valid),
    .de_insn     (de_insn),
    .de_pc       (de_pc),
    .de_stall    (de_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus.master),
    .fe_fault    (fe_fault)
  );

  int          n_checks;
  int          n_fail;
  logic        rsp_en;
  logic [31:0] err_addr;
  logic [31:0] q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory samples issue before the edge, responds in order after it
  task automatic tick();
    logic        iss;
    logic        rv;
    logic        rst;
    logic [31:0] a;
    @(negedge clk);
    iss = imem_bus.imem_req && imem_bus.imem_gnt;
    rv  = imem_bus.imem_rvalid;
    rst = reset;
    a   = imem_bus.imem_addr;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (rv) void'(q.pop_front());
      if (iss) q.push_back(a);
    end
    if (rsp_en && q.size() > 0) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = q[0] ^ 32'hC0DE_0000;
      imem_bus.imem_err    = (q[0] == err_addr);
    end else begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
      imem_bus.imem_err    = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    de_stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_bus.imem_gnt = 1'b0;
    rsp_en = 1'b1;
    err_addr = 32'hFFFF_FFFF;
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    imem_bus.imem_gnt = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata = '0;
    imem_bus.imem_err = 1'b0;

    // 1: reset values, then back-to-back fetch with 1-cycle responses
    do_reset();
    chk("rst_valid", de_valid, 0);
    chk("rst_insn", de_insn, 0);
    chk("rst_pc", de_pc, 0);
    chk("rst_req", imem_bus.imem_req, 0);
    chk("rst_addr", imem_bus.imem_addr, 32'h0);
    chk("rst_fault", fe_fault, 0);
    reset = 1'b0;
    imem_bus.imem_gnt = 1'b1;
    #1;
    chk("t1_req0", imem_bus.imem_req, 1);
    chk("t1_addr0", imem_bus.imem_addr, 32'h0);
    tick();
    chk("t1_addr4", imem_bus.imem_addr, 32'h4);
    chk("t1_nvalid", de_valid, 0);
    tick();
    chk("t1_valid", de_valid, 1);
    chk("t1_pc0", de_pc, 32'h0);
    chk("t1_insn0", de_insn, 32'hC0DE_0000);
    chk("t1_credit", imem_bus.imem_req, 0);
    tick();
    chk("t1_pc4", de_pc, 32'h4);
    chk("t1_insn4", de_insn, 32'hC0DE_0004);
    chk("t1_addr8", imem_bus.imem_addr, 32'h8);

    // 2: stall with a full buffer holds the head and blocks issue
    do_reset();
    reset = 1'b0;
    de_stall = 1'b1;
    imem_bus.imem_gnt = 1'b1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_req", imem_bus.imem_req, 0);
      chk("t2_valid", de_valid, 1);
      chk("t2_pc", de_pc, 32'h0);
      chk("t2_insn", de_insn, 32'hC0DE_0000);
      tick();
    end
    de_stall = 1'b0;
    tick();
    chk("t2_pc4", de_pc, 32'h4);
    chk("t2_insn4", de_insn, 32'hC0DE_0004);
    chk("t2_req8", imem_bus.imem_req, 1);
    chk("t2_addr8", imem_bus.imem_addr, 32'h8);

    // 3: two requests in flight, redirect drops both responses
    do_reset();
    reset = 1'b0;
    rsp_en = 1'b0;
    imem_bus.imem_gnt = 1'b1;
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    rsp_en = 1'b1;
    #1;
    chk("t3_req_redir", imem_bus.imem_req, 0);
    tick();
    redirect = 1'b0;
    #1;
    chk("t3_nvalid0", de_valid, 0);
    chk("t3_req_cred", imem_bus.imem_req, 0);
    chk("t3_addr", imem_bus.imem_addr, 32'h100);
    tick();
    chk("t3_nvalid1", de_valid, 0);
    chk("t3_req", imem_bus.imem_req, 1);
    tick();
    chk("t3_nvalid2", de_valid, 0);
    chk("t3_addr104", imem_bus.imem_addr, 32'h104);
    tick();
    chk("t3_valid", de_valid, 1);
    chk("t3_pc", de_pc, 32'h100);
    chk("t3_insn", de_insn, 32'hC0DE_0100);

    // 4: redirect in the same cycle as a response and a grant
    do_reset();
    reset = 1'b0;
    imem_bus.imem_gnt = 1'b1;
    tick();
    chk("t4_rvalid", imem_bus.imem_rvalid, 1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    chk("t4_req_redir", imem_bus.imem_req, 0);
    tick();
    chk("t4_nvalid0", de_valid, 0);
    redirect = 1'b0;
    #1;
    chk("t4_req", imem_bus.imem_req, 1);
    chk("t4_addr", imem_bus.imem_addr, 32'h200);
    tick();
    chk("t4_nvalid1", de_valid, 0);
    chk("t4_addr204", imem_bus.imem_addr, 32'h204);
    tick();
    chk("t4_valid", de_valid, 1);
    chk("t4_pc", de_pc, 32'h200);
    chk("t4_insn", de_insn, 32'hC0DE_0200);

    // 5: error response on 0x8 halts fetch until a redirect
    do_reset();
    reset = 1'b0;
    err_addr = 32'h8;
    imem_bus.imem_gnt = 1'b1;
    tick();
    tick();
    chk("t5_pc0", de_pc, 32'h0);
    chk("t5_insn0", de_insn, 32'hC0DE_0000);
    tick();
    chk("t5_pc4", de_pc, 32'h4);
    chk("t5_addr8", imem_bus.imem_addr, 32'h8);
    tick();
    chk("t5_nvalid", de_valid, 0);
    tick();
    chk("t5_fault", fe_fault, 1);
    chk("t5_noreq", imem_bus.imem_req, 0);
    chk("t5_nvalid1", de_valid, 0);
    tick();
    chk("t5_fault_hold", fe_fault, 1);
    chk("t5_nvalid2", de_valid, 0);
    err_addr = 32'hFFFF_FFFF;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    #1;
    chk("t5_run", fe_fault, 0);
    chk("t5_req40", imem_bus.imem_req, 1);
    chk("t5_addr40", imem_bus.imem_addr, 32'h40);
    tick();
    tick();
    chk("t5_valid40", de_valid, 1);
    chk("t5_pc40", de_pc, 32'h40);
    chk("t5_insn40", de_insn, 32'hC0DE_0040);

    // 6: reset mid-stream while decode is stalled
    do_reset();
    reset = 1'b0;
    de_stall = 1'b1;
    imem_bus.imem_gnt = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_valid_pre", de_valid, 1);
    reset = 1'b1;
    tick();
    chk("t6_nvalid", de_valid, 0);
    chk("t6_addr", imem_bus.imem_addr, 32'h0);
    chk("t6_req", imem_bus.imem_req, 0);
    chk("t6_insn", de_insn, 0);
    reset = 1'b0;
    de_stall = 1'b0;
    tick();
    tick();
    chk("t6_valid", de_valid, 1);
    chk("t6_pc", de_pc, 32'h0);

    // 7: low address bits ignored, grant stall holds address, PC wraps
    do_reset();
    reset = 1'b0;
    imem_bus.imem_gnt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    imem_bus.imem_gnt = 1'b0;
    #1;
    chk("t7_req", imem_bus.imem_req, 1);
    chk("t7_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t7_hold", imem_bus.imem_addr, 32'hFFFF_FFFC);
    imem_bus.imem_gnt = 1'b1;
    tick();
    chk("t7_wrap", imem_bus.imem_addr, 32'h0);
    tick();
    chk("t7_valid", de_valid, 1);
    chk("t7_pc", de_pc, 32'hFFFF_FFFC);
    chk("t7_insn", de_insn, 32'h3F21_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
